// File: rtl/KeySchedule.sv
// rtl/KeySchedule.sv - AES-128 key expansion producing round keys rk0..rk10
// Purpose: combinational key schedule.
// Ports:
//   key_i         in  128   cipher key, FIPS-197 byte order
//   round_keys_o  out 1408  rk r at [1407-128*r -: 128]; rk0 is the cipher key
module KeySchedule (
  input  logic [127:0]  key_i,
  output logic [1407:0] round_keys_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 = x^-1 in GF(2^8).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] res;
    rcon = 8'h01;
    res  = '0;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      res[1407-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return res;
  endfunction

  assign round_keys_o = expand(key_i);

endmodule

// File: rtl/inv_sub_bytes.sv
// rtl/inv_sub_bytes.sv - AES inverse S-box applied to all 16 bytes of a block
// Purpose: combinational InvSubBytes leaf.
// Ports:
//   data_i  in  128  block, FIPS-197 byte order ([127:120] = byte 0)
//   data_o  out 128  block with every byte passed through the inverse S-box
module inv_sub_bytes (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; naturally maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Undo the affine transform first, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] b;
    b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  always_comb begin
    data_o = '0;
    for (int i = 0; i < 16; i++) begin
      data_o[127-8*i -: 8] = inv_sbox(data_i[127-8*i -: 8]);
    end
  end

endmodule

// File: rtl/decryption_block.sv
// rtl/decryption_block.sv - iterative AES-128 inverse cipher, one round per clock
// Purpose: decrypts one 128-bit block per request; done pulses 11 cycles after accept.
// Ports:
//   clk            in   1    rising-edge clock
//   n_rst          in   1    asynchronous active-low reset
//   decryptEnable  in   1    start request, sampled only in IDLE
//   key            in   128  cipher key, latched on accept
//   inputData      in   128  ciphertext, latched on accept
//   outputData     out  128  plaintext, held until next completion
//   busy           out  1    high from the cycle after accept until done
//   done           out  1    one-cycle completion pulse
module decryption_block (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         decryptEnable,
  input  logic [127:0] key,
  input  logic [127:0] inputData,
  output logic [127:0] outputData,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, INIT, ROUND, FINAL} fsm_e;

  fsm_e          fsm_q;
  logic [127:0]  state_q, state_d;
  logic [127:0]  key_q;
  logic [127:0]  out_q, out_d;
  logic [3:0]    round_q, round_d;
  logic          busy_q;
  logic          done_q;

  logic [1407:0] round_keys;
  logic [127:0]  rk_sel;
  logic [127:0]  isr;
  logic [127:0]  isb;
  logic [127:0]  ark;
  logic [127:0]  imc;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Byte (row r, col c) sits at index 4c+r; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  KeySchedule u_key_schedule (
    .key_i        (key_q),
    .round_keys_o (round_keys)
  );

  inv_sub_bytes u_inv_sub_bytes (
    .data_i (isr),
    .data_o (isb)
  );

  // round_q is 0 in FINAL, so the same mux hands out rk0 for the last step.
  always_comb begin
    rk_sel = '0;
    for (int r = 0; r < 11; r++) begin
      if (round_q == 4'(r)) rk_sel = round_keys[1407-128*r -: 128];
    end
  end

  assign isr = inv_shift_rows(state_q);
  assign ark = isb ^ rk_sel;
  assign imc = inv_mix_columns(ark);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    out_d   = out_q;
    case (fsm_q)
      IDLE: begin
        if (decryptEnable) state_d = inputData;
      end
      INIT: begin
        state_d = state_q ^ round_keys[127:0];
        round_d = 4'd9;
      end
      ROUND: begin
        state_d = imc;
        round_d = round_q - 4'd1;
      end
      FINAL: begin
        out_d = ark;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      out_q   <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      out_q   <= out_d;
      done_q  <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (decryptEnable) begin
            key_q  <= key;
            busy_q <= 1'b1;
            fsm_q  <= INIT;
          end
        end
        INIT: begin
          fsm_q <= ROUND;
        end
        ROUND: begin
          if (round_q == 4'd1) fsm_q <= FINAL;
        end
        FINAL: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          fsm_q  <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign outputData = out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_decryption_block.sv
// tb/tb_decryption_block.sv - self-checking bench for decryption_block
`timescale 1ns/1ps
module tb_decryption_block;

  logic         clk;
  logic         n_rst;
  logic         decryptEnable;
  logic [127:0] key;
  logic [127:0] inputData;
  logic [127:0] outputData;
  logic         busy;
  logic         done;

  int checks;
  int failures;

  decryption_block dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .decryptEnable (decryptEnable),
    .key           (key),
    .inputData     (inputData),
    .outputData    (outputData),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  logic [7:0] sb [0:255];

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [1407:0] m_expand(input logic [127:0] k);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) res[1407-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  function automatic logic [127:0] m_round(input logic [127:0] s, input bit mix);
    logic [7:0]   st [0:3][0:3];
    logic [7:0]   sh [0:3][0:3];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[r][c] = sb[s[127-8*(4*c+r) -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sh[r][c] = st[r][(c+r)%4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (mix)
          o[127-8*(4*c+r) -: 8] = m_mul(8'h02, sh[r][c]) ^ m_mul(8'h03, sh[(r+1)%4][c]) ^
                                  sh[(r+2)%4][c] ^ sh[(r+3)%4][c];
        else
          o[127-8*(4*c+r) -: 8] = sh[r][c];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [1407:0] rks;
    logic [127:0]  s;
    rks = m_expand(k);
    s = pt ^ rks[1407 -: 128];
    for (int r = 1; r < 10; r++) s = m_round(s, 1'b1) ^ rks[1407-128*r -: 128];
    s = m_round(s, 1'b0) ^ rks[127:0];
    return s;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  logic         prev_done;
  logic         prev_rst;
  logic [127:0] prev_out;
  initial begin
    prev_done = 1'b0;
    prev_rst  = 1'b0;
    prev_out  = '0;
  end

  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (prev_done) begin
        failures++;
        $display("FAIL done_twice actual=1 expected=0");
      end
    end
    if (n_rst && prev_rst && (outputData !== prev_out)) begin
      checks++;
      if (!done) begin
        failures++;
        $display("FAIL out_changed_without_done actual=%h expected=%h", outputData, prev_out);
      end
    end
    prev_done = done;
    prev_rst  = n_rst;
    prev_out  = outputData;
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts from a negedge with the DUT in IDLE; returns at the negedge of the done cycle.
  task automatic run_one(input logic [127:0] k, input logic [127:0] c,
                         input logic [127:0] exp_pt, input bit scramble, input string tag);
    int cyc;
    bit got;
    bit busy_ok;
    key = k;
    inputData = c;
    decryptEnable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    decryptEnable = 1'b0;
    busy_ok = (busy === 1'b1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      if (scramble) begin
        key = rnd128();
        inputData = rnd128();
      end
      @(negedge clk);
      cyc++;
      if (done === 1'b1) got = 1'b1;
      else if (busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, 128'(cyc), 128'd11);
    chk({tag, "_busy_during"}, 128'(busy_ok), 128'd1);
    chk({tag, "_busy_in_done"}, 128'(busy), 128'd0);
    chk({tag, "_pt"}, outputData, exp_pt);
  endtask

  typedef struct {
    logic [127:0] k;
    logic [127:0] ct;
    logic [127:0] pt;
    bit           scramble;
  } vec_t;

  vec_t vecs [0:2];

  initial begin
    int cyc;
    int dones;
    bit busy_ok;
    logic [127:0] rk;
    logic [127:0] rp;

    checks = 0;
    failures = 0;
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff, 1'b0};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734, 1'b1};
    vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 1'b1};

    build_sbox();

    // reset with a start request held: nothing may start
    n_rst = 1'b0;
    decryptEnable = 1'b1;
    key = vecs[0].k;
    inputData = vecs[0].ct;
    repeat (3) @(negedge clk);
    chk("reset_out", outputData, 128'h0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    n_rst = 1'b1;
    decryptEnable = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_busy", 128'(busy), 128'd0);

    for (int i = 0; i < 3; i++)
      run_one(vecs[i].k, vecs[i].ct, vecs[i].pt, vecs[i].scramble, $sformatf("vec%0d", i));

    // back-to-back with decryptEnable held high
    key = vecs[0].k;
    inputData = vecs[0].ct;
    decryptEnable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key = vecs[1].k;
    inputData = vecs[1].ct;
    busy_ok = (busy === 1'b1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
    end
    chk("b2b_first_latency", 128'(cyc), 128'd11);
    chk("b2b_first_pt", outputData, vecs[0].pt);
    chk("b2b_first_busy_done", 128'(busy), 128'd0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) decryptEnable = 1'b0;
      if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
    end while (done !== 1'b1 && cyc < 40);
    chk("b2b_gap", 128'(cyc), 128'd12);
    chk("b2b_second_pt", outputData, vecs[1].pt);
    chk("b2b_busy", 128'(busy_ok), 128'd1);

    // abort at round 5, then restart
    key = vecs[0].k;
    inputData = vecs[0].ct;
    decryptEnable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    decryptEnable = 1'b0;
    repeat (5) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("abort_out", outputData, 128'h0);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", 128'(dones), 128'd0);
    chk("abort_out_held", outputData, 128'h0);
    run_one(vecs[0].k, vecs[0].ct, vecs[0].pt, 1'b0, "restart");

    // random loopback against the model cipher
    for (int i = 0; i < 1000; i++) begin
      rk = rnd128();
      rp = rnd128();
      run_one(rk, m_encrypt(rp, rk), rp, i[0], $sformatf("loop%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
